// File: rtl/clock_ui_pkg.sv
// Shared UI definitions for the multimode clock: state encodings and button indices.
// The timekeeper and display mux decode the same mode values.
package clock_ui_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_CLOCK      = 3'd0;
  localparam mode_t MODE_STOPWATCH  = 3'd1;
  localparam mode_t MODE_ALARM_VIEW = 3'd2;
  localparam mode_t MODE_SET_HR     = 3'd3;
  localparam mode_t MODE_SET_MIN    = 3'd4;
  localparam mode_t MODE_ASET_HR    = 3'd5;
  localparam mode_t MODE_ASET_MIN   = 3'd6;

  localparam int BTN_MODE = 0;
  localparam int BTN_SET  = 1;
  localparam int BTN_UP   = 2;
  localparam int BTN_DOWN = 3;
  localparam int NUM_BTN  = 4;

  function automatic logic is_edit_mode(input mode_t m);
    return (m >= MODE_SET_HR) && (m <= MODE_ASET_MIN);
  endfunction

  function automatic logic is_alarm_edit(input mode_t m);
    return (m == MODE_ASET_HR) || (m == MODE_ASET_MIN);
  endfunction

endpackage

// File: rtl/hold_repeat_timer.sv
// Long-press auto-repeat timer: after arming, fires once at HOLD_CYC and then every
// REPEAT_CYC cycles while the level stays high.
module hold_repeat_timer #(
  parameter int          CNT_W      = 30,
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic arm,
  input  logic level,
  input  logic disarm,
  output logic fire
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             armed;
  logic             rep_phase;
  logic [CNT_W-1:0] cnt;
  logic             at_last;

  assign at_last = (cnt == (rep_phase ? REP_LAST : HOLD_LAST));
  assign fire    = armed & level & at_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      armed     <= 1'b0;
      rep_phase <= 1'b0;
      cnt       <= '0;
    end else if (arm) begin
      armed     <= 1'b1;
      rep_phase <= 1'b0;
      cnt       <= '0;
    end else if (disarm || !level) begin
      armed     <= 1'b0;
      rep_phase <= 1'b0;
      cnt       <= '0;
    end else if (armed) begin
      if (at_last) begin
        rep_phase <= 1'b1;
        cnt       <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_mode_controller.sv
// UI controller for the multimode clock: arbitrates button pulses, runs the mode FSM,
// and adds auto-repeat and an edit inactivity timeout.
//
//  state       | meaning
//  CLOCK       | time view
//  STOPWATCH   | stopwatch view, UP starts/stops, SET clears
//  ALARM_VIEW  | alarm view, UP toggles alarm enable
//  SET_HR      | editing time hours
//  SET_MIN     | editing time minutes, SET commits
//  ASET_HR     | editing alarm hours
//  ASET_MIN    | editing alarm minutes, SET commits
module button_mode_controller
  import clock_ui_pkg::*;
#(
  parameter int          CNT_W       = 30,
  parameter int unsigned HOLD_CYC    = 50_000_000,
  parameter int unsigned REPEAT_CYC  = 10_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTN-1:0]  btn_pulse,
  input  logic [NUM_BTN-1:0]  btn_level,
  output logic [2:0]          mode,
  output logic                editing,
  output logic                inc,
  output logic                dec,
  output logic                commit,
  output logic                abort,
  output logic                sw_run,
  output logic                sw_clear,
  output logic                alarm_en
);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_MAX  = '1;

  mode_t            state;
  mode_t            state_nxt;
  logic             take_mode;
  logic             take_set;
  logic             take_up;
  logic             take_down;
  logic             take_any;
  logic             edit_now;
  logic             fire;
  logic             fire_used;
  logic             timeout_hit;
  logic             arm;
  logic             disarm;
  logic             armed_dn;
  logic             hold_level;
  logic [CNT_W-1:0] idle_cnt;
  logic             inc_n;
  logic             dec_n;
  logic             commit_n;
  logic             abort_n;
  logic             sw_clear_n;
  logic             sw_run_n;
  logic             alarm_en_n;
  logic             unused_levels;

  // MODE and SET levels carry no hold behaviour
  assign unused_levels = ^btn_level[BTN_SET:BTN_MODE];

  assign take_mode = btn_pulse[BTN_MODE];
  assign take_set  = btn_pulse[BTN_SET]  & ~btn_pulse[BTN_MODE];
  assign take_up   = btn_pulse[BTN_UP]   & ~btn_pulse[BTN_SET] & ~btn_pulse[BTN_MODE];
  assign take_down = btn_pulse[BTN_DOWN] & ~btn_pulse[BTN_UP]  & ~btn_pulse[BTN_SET]
                   & ~btn_pulse[BTN_MODE];
  assign take_any  = |btn_pulse;

  assign edit_now    = is_edit_mode(state);
  assign fire_used   = fire & edit_now & ~take_any;
  assign timeout_hit = edit_now & ~take_any & ~fire_used & (idle_cnt == IDLE_LAST);

  // A fresh UP/DOWN re-arms; anything else accepted, or leaving edit, disarms.
  assign arm        = edit_now & (take_up | take_down);
  assign disarm     = (take_any & ~arm) | ~edit_now | timeout_hit;
  assign hold_level = armed_dn ? btn_level[BTN_DOWN] : btn_level[BTN_UP];

  hold_repeat_timer #(
    .CNT_W      (CNT_W),
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_hold_repeat_timer (
    .clk    (clk),
    .reset  (reset),
    .arm    (arm),
    .level  (hold_level),
    .disarm (disarm),
    .fire   (fire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_dn <= 1'b0;
    end else if (arm) begin
      armed_dn <= take_down;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (!edit_now || take_any || fire_used) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MODE_CLOCK;
      editing  <= 1'b0;
      inc      <= 1'b0;
      dec      <= 1'b0;
      commit   <= 1'b0;
      abort    <= 1'b0;
      sw_run   <= 1'b0;
      sw_clear <= 1'b0;
      alarm_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      editing  <= is_edit_mode(state_nxt);
      inc      <= inc_n;
      dec      <= dec_n;
      commit   <= commit_n;
      abort    <= abort_n;
      sw_run   <= sw_run_n;
      sw_clear <= sw_clear_n;
      alarm_en <= alarm_en_n;
    end
  end

  assign mode = state;

  always_comb begin
    state_nxt = state;
    case (state)
      MODE_CLOCK: begin
        if (take_mode)     state_nxt = MODE_STOPWATCH;
        else if (take_set) state_nxt = MODE_SET_HR;
      end
      MODE_STOPWATCH: begin
        if (take_mode) state_nxt = MODE_ALARM_VIEW;
      end
      MODE_ALARM_VIEW: begin
        if (take_mode)     state_nxt = MODE_CLOCK;
        else if (take_set) state_nxt = MODE_ASET_HR;
      end
      MODE_SET_HR: begin
        if (take_mode || timeout_hit) state_nxt = MODE_CLOCK;
        else if (take_set)            state_nxt = MODE_SET_MIN;
      end
      MODE_SET_MIN: begin
        if (take_mode || take_set || timeout_hit) state_nxt = MODE_CLOCK;
      end
      MODE_ASET_HR: begin
        if (take_mode || timeout_hit) state_nxt = MODE_ALARM_VIEW;
        else if (take_set)            state_nxt = MODE_ASET_MIN;
      end
      MODE_ASET_MIN: begin
        if (take_mode || take_set || timeout_hit) state_nxt = MODE_ALARM_VIEW;
      end
      default: state_nxt = MODE_CLOCK;
    endcase
  end

  always_comb begin
    inc_n      = 1'b0;
    dec_n      = 1'b0;
    commit_n   = 1'b0;
    abort_n    = 1'b0;
    sw_clear_n = 1'b0;
    sw_run_n   = sw_run;
    alarm_en_n = alarm_en;
    if (edit_now) begin
      if (take_mode || timeout_hit) begin
        abort_n = 1'b1;
      end else if (take_set) begin
        commit_n = (state == MODE_SET_MIN) || (state == MODE_ASET_MIN);
      end else if (take_up) begin
        inc_n = 1'b1;
      end else if (take_down) begin
        dec_n = 1'b1;
      end else if (fire_used) begin
        inc_n = ~armed_dn;
        dec_n = armed_dn;
      end
    end else if (state == MODE_STOPWATCH) begin
      if (take_set) begin
        sw_clear_n = 1'b1;
        sw_run_n   = 1'b0;
      end else if (take_up) begin
        sw_run_n = ~sw_run;
      end
    end else if (state == MODE_ALARM_VIEW) begin
      if (take_up) alarm_en_n = ~alarm_en;
    end
  end

endmodule

// File: tb/tb_button_mode_controller.sv
// Bench for button_mode_controller: directed scenarios plus random button traffic,
// every cycle compared against a cycle-stamped behavioural model.
module tb_button_mode_controller;

  localparam int HOLD = 8;
  localparam int RPT  = 3;
  localparam int TMO  = 20;

  localparam int S_CLOCK = 0, S_SW = 1, S_AV = 2, S_SHR = 3, S_SMIN = 4, S_AHR = 5, S_AMIN = 6;
  localparam int B_UP = 2, B_DN = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_pulse = 4'b0;
  logic [3:0] btn_level = 4'b0;
  logic [2:0] mode;
  logic       editing, inc, dec, commit, abort, sw_run, sw_clear, alarm_en;

  int total = 0;
  int bad   = 0;

  // model state: repeat and timeout tracked as absolute cycle stamps
  int m_mode = S_CLOCK;
  bit m_run, m_alarm, m_armed;
  int m_btn, next_rep, last_act;
  int cyc = 0;
  bit e_inc, e_dec, e_commit, e_abort, e_clr;

  int incs[$];
  int exp_inc[5] = '{1, 9, 12, 15, 18};
  int ab_at, n_ab, n_inc;
  logic [3:0] lv, pp;

  button_mode_controller #(
    .CNT_W(30), .HOLD_CYC(HOLD), .REPEAT_CYC(RPT), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .btn_pulse(btn_pulse), .btn_level(btn_level),
    .mode(mode), .editing(editing), .inc(inc), .dec(dec), .commit(commit),
    .abort(abort), .sw_run(sw_run), .sw_clear(sw_clear), .alarm_en(alarm_en)
  );

  always #5 clk = ~clk;

  function automatic bit in_edit(input int m);
    return (m >= S_SHR) && (m <= S_AMIN);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input logic [3:0] p, input logic [3:0] l);
    int win;
    bit ed, rep, tmo;
    e_inc = 0; e_dec = 0; e_commit = 0; e_abort = 0; e_clr = 0;
    if (r) begin
      m_mode = S_CLOCK; m_run = 0; m_alarm = 0; m_armed = 0;
      cyc++;
      return;
    end
    win = -1;
    for (int b = 3; b >= 0; b--) if (p[b]) win = b;
    ed = in_edit(m_mode);
    if (m_armed && l[m_btn] !== 1'b1) m_armed = 0;
    rep = m_armed && ed && win < 0 && cyc == next_rep;
    tmo = ed && win < 0 && !rep && (cyc - last_act) == TMO;
    if (win >= 0 || rep) last_act = cyc;
    if (rep) begin
      next_rep = cyc + RPT;
      if (m_btn == B_UP) e_inc = 1; else e_dec = 1;
    end
    case (win)
      0: begin
        if (m_mode == S_CLOCK) m_mode = S_SW;
        else if (m_mode == S_SW) m_mode = S_AV;
        else if (m_mode == S_AV) m_mode = S_CLOCK;
        else begin
          e_abort = 1;
          m_mode = (m_mode >= S_AHR) ? S_AV : S_CLOCK;
        end
      end
      1: begin
        if (m_mode == S_CLOCK) m_mode = S_SHR;
        else if (m_mode == S_SHR) m_mode = S_SMIN;
        else if (m_mode == S_SMIN) begin m_mode = S_CLOCK; e_commit = 1; end
        else if (m_mode == S_AV) m_mode = S_AHR;
        else if (m_mode == S_AHR) m_mode = S_AMIN;
        else if (m_mode == S_AMIN) begin m_mode = S_AV; e_commit = 1; end
        else begin e_clr = 1; m_run = 0; end
      end
      2: begin
        if (ed) e_inc = 1;
        else if (m_mode == S_SW) m_run = !m_run;
        else if (m_mode == S_AV) m_alarm = !m_alarm;
      end
      3: if (ed) e_dec = 1;
      default: if (tmo) begin
        e_abort = 1;
        m_mode = (m_mode >= S_AHR) ? S_AV : S_CLOCK;
      end
    endcase
    if (ed && (win == B_UP || win == B_DN)) begin
      m_armed = 1; m_btn = win; next_rep = cyc + HOLD;
    end else if (win >= 0 || !in_edit(m_mode)) begin
      m_armed = 0;
    end
    cyc++;
  endtask

  task automatic step(input bit r, input logic [3:0] p, input logic [3:0] l);
    reset = r; btn_pulse = p; btn_level = l;
    @(posedge clk);
    #1;
    model(r, p, l);
    chk($sformatf("outputs@%0d", cyc),
        {mode, editing, inc, dec, commit, abort, sw_run, sw_clear, alarm_en},
        {3'(m_mode), in_edit(m_mode), e_inc, e_dec, e_commit, e_abort, m_run, e_clr, m_alarm});
    btn_pulse = 4'b0;
  endtask

  initial begin
    step(1, 4'b0, 4'b0);
    step(1, 4'b0, 4'b0);
    chk("reset_mode", mode, S_CLOCK);
    chk("reset_run", sw_run, 0);

    // 1: SET walk with commit on exit
    step(0, 4'b0010, 4'b0); chk("s1_set_hr", mode, S_SHR);
    step(0, 4'b0010, 4'b0); chk("s1_set_min", mode, S_SMIN);
    step(0, 4'b0010, 4'b0); chk("s1_commit", commit, 1); chk("s1_no_abort", abort, 0);
    chk("s1_clock", mode, S_CLOCK);
    step(0, 4'b0, 4'b0); chk("s1_commit_once", commit, 0);

    // 2: auto-repeat timing in SET_HR
    step(0, 4'b0010, 4'b0);
    for (int j = 0; j < 24; j++) begin
      step(0, (j == 0) ? 4'b0100 : 4'b0000, (j < 20) ? 4'b0100 : 4'b0000);
      if (inc === 1'b1) incs.push_back(j + 1);
    end
    chk("s2_inc_count", incs.size(), 5);
    for (int k = 0; k < 5 && k < incs.size(); k++) chk($sformatf("s2_inc%0d", k), incs[k], exp_inc[k]);

    // 3: MODE beats UP in SET_MIN
    step(0, 4'b0010, 4'b0); chk("s3_set_min", mode, S_SMIN);
    step(0, 4'b0101, 4'b0100);
    chk("s3_mode", mode, S_CLOCK); chk("s3_abort", abort, 1); chk("s3_no_inc", inc, 0);

    // 4: inactivity timeout in ASET_HR
    step(0, 4'b0001, 4'b0); step(0, 4'b0001, 4'b0); step(0, 4'b0010, 4'b0);
    chk("s4_aset_hr", mode, S_AHR);
    ab_at = -1; n_ab = 0;
    for (int j = 1; j <= 25; j++) begin
      step(0, 4'b0, 4'b0);
      if (abort === 1'b1) begin n_ab++; if (ab_at < 0) ab_at = j; end
    end
    chk("s4_abort_at", ab_at, 20); chk("s4_abort_once", n_ab, 1);
    chk("s4_mode_av", mode, S_AV); chk("s4_alarm_kept", alarm_en, 0);
    step(0, 4'b0010, 4'b0);
    ab_at = -1;
    for (int j = 1; j <= 45; j++) begin
      step(0, (j == 19) ? 4'b0100 : 4'b0000, 4'b0);
      if (abort === 1'b1 && ab_at < 0) ab_at = j;
    end
    chk("s4_restart_abort_at", ab_at, 39);

    // 5: stopwatch and alarm toggles
    step(0, 4'b0001, 4'b0); step(0, 4'b0001, 4'b0); chk("s5_sw", mode, S_SW);
    step(0, 4'b0100, 4'b0); chk("s5_run1", sw_run, 1);
    step(0, 4'b0100, 4'b0); chk("s5_run0", sw_run, 0);
    step(0, 4'b0100, 4'b0); chk("s5_run1b", sw_run, 1);
    step(0, 4'b0010, 4'b0); chk("s5_clear", sw_clear, 1); chk("s5_run_forced0", sw_run, 0);
    step(0, 4'b0, 4'b0);    chk("s5_clear_once", sw_clear, 0);
    step(0, 4'b0001, 4'b0); chk("s5_av", mode, S_AV);
    step(0, 4'b0100, 4'b0); chk("s5_alarm_en", alarm_en, 1);

    // 6: reset during held auto-repeat
    step(0, 4'b0001, 4'b0); step(0, 4'b0010, 4'b0); step(0, 4'b0010, 4'b0);
    chk("s6_set_min", mode, S_SMIN);
    step(0, 4'b0100, 4'b0100);
    for (int j = 0; j < 11; j++) step(0, 4'b0, 4'b0100);
    step(1, 4'b0, 4'b0100);
    chk("s6_mode", mode, S_CLOCK); chk("s6_inc", inc, 0);
    chk("s6_commit", commit, 0); chk("s6_abort", abort, 0);
    n_inc = 0;
    for (int j = 0; j < 15; j++) begin
      step(0, 4'b0, 4'b0100);
      if (inc === 1'b1) n_inc++;
    end
    chk("s6_no_repeat", n_inc, 0);

    // random traffic, alternating dense and sparse phases
    lv = 4'b0;
    for (int i = 0; i < 3000; i++) begin
      int r, dens;
      dens = ((i / 200) % 2 == 1) ? 60 : 10;
      if ($urandom_range(0, 7) == 0) lv[$urandom_range(0, 3)] ^= 1'b1;
      r = $urandom_range(0, dens);
      pp = (r < 4) ? 4'(1 << $urandom_range(0, 3)) : (r == 4) ? 4'($urandom_range(0, 15)) : 4'b0;
      lv = lv | (pp & 4'b1100);
      step(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, pp, lv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
